// File: rtl/omp_atom_select.sv
// omp_atom_select
//   Atom selection stage of one OMP iteration. It takes the winning column
//   index lambda from the argmax stage and rejects it if it is out of range,
//   if the support list is full, or if it is already in the list. Otherwise it
//   copies rows 0..M of phi column lambda from the phi BRAM into the next free
//   slot of the selected-atom BRAM, then appends lambda to the support list.
//   N and M are sampled on start, so 4x4 (N=15, M=1) and 8x8 (N=63, M=7)
//   problems can share one build.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   clear          synchronous: empty the support list and abort any operation
//   start, lambda  1-cycle request carrying the candidate column index
//   N, M           last valid column / row index, sampled with start
//   phi_addr       phi read address {lambda, row}; holds outside the fetch
//   phi_data       phi read data, RD_LAT cycles after phi_addr
//   a_we/a_addr    atom BRAM write strobe and address {slot, row}
//   a_din          atom BRAM write data (phi_data passed straight through)
//   atom_cnt       number of stored atoms, 0..K_MAX
//   idx_list       support indices, slot s at [6s+5:6s], unused slots zero
//   busy, done     operation in flight / 1-cycle completion pulse
//   status         00 ok, 01 duplicate, 10 full, 11 out of range
module omp_atom_select #(
  parameter int K_MAX  = 8,
  parameter int RD_LAT = 1,
  parameter int DW     = 96
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       start,
  input  logic [5:0]                 lambda,
  input  logic [5:0]                 N,
  input  logic [2:0]                 M,
  output logic [8:0]                 phi_addr,
  input  logic [DW-1:0]              phi_data,
  output logic                       a_we,
  output logic [$clog2(K_MAX)+2:0]   a_addr,
  output logic [DW-1:0]              a_din,
  output logic [$clog2(K_MAX+1)-1:0] atom_cnt,
  output logic [6*K_MAX-1:0]         idx_list,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 status
);

  localparam int SW = $clog2(K_MAX);
  localparam int CW = $clog2(K_MAX + 1);
  localparam int IW = 6;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_DUP   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_RANGE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                      state_r;
  logic [5:0]                  lam_r;
  logic [5:0]                  n_r;
  logic [2:0]                  m_r;
  logic [SW-1:0]               slot_r;
  logic [2:0]                  row_r;
  logic [1:0]                  drain_r;
  logic [CW-1:0]               cnt_r;
  logic [IW*K_MAX-1:0]         list_r;
  logic [1:0]                  status_r;
  logic                        done_r;
  logic                        busy_r;
  logic [8:0]                  phi_addr_r;
  logic [RD_LAT-1:0]           we_pipe_r;
  logic [RD_LAT-1:0][SW+2:0]   addr_pipe_r;
  logic                        dup_s;
  logic                        full_s;
  logic                        range_s;

  // Reject conditions evaluated in CHECK; only occupied slots count as duplicates.
  always_comb begin
    dup_s = 1'b0;
    for (int s = 0; s < K_MAX; s++) begin
      dup_s = dup_s | ((CW'(s) < cnt_r) && (list_r[s*IW +: IW] == lam_r));
    end
    full_s  = (cnt_r == CW'(K_MAX));
    range_s = (lam_r > n_r);
  end

  // Control FSM: request capture, reject decision, row fetch, drain and list update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      lam_r      <= '0;
      n_r        <= '0;
      m_r        <= '0;
      slot_r     <= '0;
      row_r      <= '0;
      drain_r    <= '0;
      cnt_r      <= '0;
      list_r     <= '0;
      status_r   <= ST_OK;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      phi_addr_r <= '0;
    end else if (clear) begin
      // Abort wins over everything, including a start in the same cycle.
      state_r <= IDLE;
      cnt_r   <= '0;
      list_r  <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            lam_r    <= lambda;
            n_r      <= N;
            m_r      <= M;
            slot_r   <= cnt_r[SW-1:0];
            status_r <= ST_OK;
            busy_r   <= 1'b1;
            state_r  <= CHECK;
          end
        end
        CHECK: begin
          if (range_s) begin
            status_r <= ST_RANGE;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else if (full_s) begin
            status_r <= ST_FULL;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else if (dup_s) begin
            status_r <= ST_DUP;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            row_r      <= 3'd0;
            phi_addr_r <= {lam_r, 3'd0};
            state_r    <= FETCH;
          end
        end
        FETCH: begin
          // Stop on row == M so a 3-bit counter never wraps for M = 7.
          if (row_r == m_r) begin
            drain_r <= 2'd0;
            state_r <= DRAIN;
          end else begin
            row_r      <= row_r + 3'd1;
            phi_addr_r <= {lam_r, row_r + 3'd1};
          end
        end
        DRAIN: begin
          // The list update lands together with done, so atom_cnt is final on the pulse.
          if (drain_r == 2'(RD_LAT - 1)) begin
            list_r[slot_r*IW +: IW] <= lam_r;
            cnt_r                   <= cnt_r + CW'(1'b1);
            status_r                <= ST_OK;
            done_r                  <= 1'b1;
            state_r                 <= DONE;
          end else begin
            drain_r <= drain_r + 2'd1;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Write strobe/address delay line matching the phi BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_pipe_r   <= '0;
      addr_pipe_r <= '0;
    end else if (clear) begin
      we_pipe_r <= '0;
    end else begin
      we_pipe_r[0] <= (state_r == FETCH);
      if (state_r == FETCH) begin
        addr_pipe_r[0] <= {slot_r, row_r};
      end
      for (int i = 1; i < RD_LAT; i++) begin
        we_pipe_r[i] <= we_pipe_r[i-1];
        if (we_pipe_r[i-1]) begin
          addr_pipe_r[i] <= addr_pipe_r[i-1];
        end
      end
    end
  end

  assign phi_addr = phi_addr_r;
  assign a_we     = we_pipe_r[RD_LAT-1];
  assign a_addr   = addr_pipe_r[RD_LAT-1];
  assign a_din    = phi_data;
  assign atom_cnt = cnt_r;
  assign idx_list = list_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign status   = status_r;

endmodule

// File: tb/tb_omp_atom_select.sv
// Testbench for omp_atom_select. Two instances (RD_LAT = 1 and RD_LAT = 2)
// share one stimulus stream, and each has its own phi BRAM model. A
// cycle-level reference model derives every output from the operation's
// start cycle, its reject decision and the support list.
module tb_omp_atom_select;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       start;
  logic [5:0] lambda;
  logic [5:0] n_in;
  logic [2:0] m_in;

  wire [8:0]  phi_addr [2];
  wire [95:0] phi_data [2];
  wire        a_we     [2];
  wire [5:0]  a_addr   [2];
  wire [95:0] a_din    [2];
  wire [3:0]  atom_cnt [2];
  wire [47:0] idx_list [2];
  wire        busy     [2];
  wire        done     [2];
  wire [1:0]  status   [2];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model state, one copy per lane (lane g has read latency g+1).
  int         cnt_m  [2];
  logic [5:0] lst_m  [2][8];
  bit         act_m  [2];
  int         t0_m   [2];
  logic [5:0] lam_m  [2];
  int         mm_m   [2];
  int         slot_m [2];
  bit         rej_m  [2];
  logic [1:0] st_m   [2];
  logic [1:0] sth_m  [2];
  logic [8:0] pa_m   [2];

  function automatic logic [95:0] phi_word(input logic [8:0] a);
    logic [31:0] x;
    x = {23'd0, a} * 32'h9E37_79B1 + 32'h0F1E_2D3C;
    return {x, ~x, x ^ 32'hA5A5_A5A5};
  endfunction

  task automatic check(input string name, input int lane, input logic [127:0] got,
                       input logic [127:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s lane%0d: got %0h expected %0h", name, lane, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [95:0] d1;
    logic [95:0] d2;
    omp_atom_select #(.K_MAX(8), .RD_LAT(g + 1), .DW(96)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .lambda(lambda),
      .N(n_in), .M(m_in), .phi_addr(phi_addr[g]), .phi_data(phi_data[g]),
      .a_we(a_we[g]), .a_addr(a_addr[g]), .a_din(a_din[g]), .atom_cnt(atom_cnt[g]),
      .idx_list(idx_list[g]), .busy(busy[g]), .done(done[g]), .status(status[g])
    );
    always @(posedge clk) begin
      d1 <= phi_word(phi_addr[g]);
      d2 <= d1;
    end
    assign phi_data[g] = (g == 0) ? d1 : d2;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare process: check the current cycle, then advance the model with the inputs now applied.
  always @(negedge clk) begin
    int off;
    int doff;
    int row;
    bit ew;
    bit ed;
    bit eb;
    logic [47:0] pk;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        cnt_m[g] = 0;
        for (int s = 0; s < 8; s++) lst_m[g][s] = 6'd0;
        act_m[g] = 1'b0;
        sth_m[g] = 2'b00;
        pa_m[g]  = 9'd0;
        check("rst_a_we", g, a_we[g], 0);
        check("rst_done", g, done[g], 0);
        check("rst_busy", g, busy[g], 0);
        check("rst_status", g, status[g], 0);
        check("rst_atom_cnt", g, atom_cnt[g], 0);
        check("rst_idx_list", g, idx_list[g], 0);
        check("rst_phi_addr", g, phi_addr[g], 0);
        check("rst_a_addr", g, a_addr[g], 0);
      end else begin
        off  = cyc - t0_m[g];
        doff = rej_m[g] ? 2 : mm_m[g] + (g + 1) + 3;
        ew = act_m[g] && !rej_m[g] && (off >= 2 + g + 1) && (off <= 2 + mm_m[g] + g + 1);
        ed = act_m[g] && (off == doff);
        eb = act_m[g] && (off >= 1) && (off <= doff);
        if (act_m[g] && !rej_m[g] && off >= 2 && off <= 2 + mm_m[g]) begin
          pa_m[g] = {lam_m[g], 3'(off - 2)};
        end
        if (ed) begin
          if (!rej_m[g]) begin
            lst_m[g][slot_m[g]] = lam_m[g];
            cnt_m[g]++;
          end
          sth_m[g] = st_m[g];
        end
        pk = '0;
        for (int s = 0; s < 8; s++) pk[6*s +: 6] = lst_m[g][s];
        check("a_we", g, a_we[g], ew);
        check("done", g, done[g], ed);
        check("busy", g, busy[g], eb);
        check("status", g, status[g], sth_m[g]);
        check("atom_cnt", g, atom_cnt[g], cnt_m[g]);
        check("idx_list", g, idx_list[g], pk);
        check("phi_addr", g, phi_addr[g], pa_m[g]);
        if (ew) begin
          row = off - 2 - (g + 1);
          check("a_addr", g, a_addr[g], {3'(slot_m[g]), 3'(row)});
          check("a_din", g, a_din[g], phi_word({lam_m[g], 3'(row)}));
        end
        if (act_m[g] && off > doff) act_m[g] = 1'b0;
        if (clear) begin
          cnt_m[g] = 0;
          for (int s = 0; s < 8; s++) lst_m[g][s] = 6'd0;
          act_m[g] = 1'b0;
        end else if (start && !act_m[g]) begin
          t0_m[g]   = cyc;
          lam_m[g]  = lambda;
          mm_m[g]   = int'(m_in);
          slot_m[g] = cnt_m[g];
          sth_m[g]  = 2'b00;
          act_m[g]  = 1'b1;
          if (lambda > n_in) begin
            st_m[g] = 2'b11;
          end else if (cnt_m[g] == 8) begin
            st_m[g] = 2'b10;
          end else begin
            st_m[g] = 2'b00;
            for (int s = 0; s < cnt_m[g]; s++) begin
              if (lst_m[g][s] == lambda) st_m[g] = 2'b01;
            end
          end
          rej_m[g] = (st_m[g] != 2'b00);
        end
      end
    end
  end

  // One request; reports the start->done distance per lane (-1 if no done seen).
  task automatic do_op(input logic [5:0] lam, input logic [5:0] n, input logic [2:0] m,
                       output int lat0, output int lat1);
    @(posedge clk); #2;
    start = 1'b1; lambda = lam; n_in = n; m_in = m;
    @(posedge clk); #2;
    start = 1'b0;
    lat0 = -1;
    lat1 = -1;
    for (int k = 1; k <= 20; k++) begin
      if (done[0] && lat0 < 0) lat0 = k;
      if (done[1] && lat1 < 0) lat1 = k;
      @(posedge clk); #2;
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #2;
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
  endtask

  initial begin
    int l0;
    int l1;
    int nd;
    rst_n = 1'b1; clear = 1'b0; start = 1'b0; lambda = 6'd0; n_in = 6'd63; m_in = 3'd7;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 8x8 accepted pick: 11 / 12 cycles start->done.
    do_op(6'd5, 6'd63, 3'd7, l0, l1);
    check("t1_latency", 0, l0, 11);
    check("t1_latency", 1, l1, 12);
    for (int g = 0; g < 2; g++) begin
      check("t1_status", g, status[g], 2'b00);
      check("t1_cnt", g, atom_cnt[g], 1);
      check("t1_list", g, idx_list[g], 48'd5);
    end

    // 4x4 duplicate.
    pulse_clear();
    do_op(6'd3, 6'd15, 3'd1, l0, l1);
    check("t2_latency", 0, l0, 5);
    check("t2_latency", 1, l1, 6);
    do_op(6'd3, 6'd15, 3'd1, l0, l1);
    check("t2_dup_latency", 0, l0, 2);
    check("t2_dup_latency", 1, l1, 2);
    for (int g = 0; g < 2; g++) begin
      check("t2_status", g, status[g], 2'b01);
      check("t2_cnt", g, atom_cnt[g], 1);
    end

    // Out of range, then the last valid column.
    do_op(6'd20, 6'd15, 3'd1, l0, l1);
    check("t3_range_latency", 0, l0, 2);
    for (int g = 0; g < 2; g++) check("t3_status", g, status[g], 2'b11);
    do_op(6'd15, 6'd15, 3'd1, l0, l1);
    for (int g = 0; g < 2; g++) begin
      check("t3_edge_status", g, status[g], 2'b00);
      check("t3_list", g, idx_list[g], {36'd0, 6'd15, 6'd3});
    end

    // Fill all eight slots, then a ninth pick is rejected as full.
    pulse_clear();
    for (int i = 0; i < 8; i++) do_op(6'(i), 6'd63, 3'd1, l0, l1);
    do_op(6'd9, 6'd63, 3'd1, l0, l1);
    for (int g = 0; g < 2; g++) begin
      check("t4_status", g, status[g], 2'b10);
      check("t4_cnt", g, atom_cnt[g], 8);
      check("t4_list", g, idx_list[g], 48'h1C61_440C_2040);
    end

    // Clear during fetch row 3; a start while busy is ignored.
    pulse_clear();
    @(posedge clk); #2;
    start = 1'b1; lambda = 6'd10; n_in = 6'd63; m_in = 3'd7;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; lambda = 6'd11;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    for (int g = 0; g < 2; g++) check("t5_row3", g, phi_addr[g], {6'd10, 3'd3});
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
    nd = 0;
    for (int g = 0; g < 2; g++) check("t5_we_killed", g, a_we[g], 0);
    for (int k = 0; k < 15; k++) begin
      if (done[0] || done[1]) nd++;
      @(posedge clk); #2;
    end
    check("t5_no_done", 0, nd, 0);
    for (int g = 0; g < 2; g++) check("t5_cnt", g, atom_cnt[g], 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      clear  = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 3) == 0);
      lambda = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 11));
      n_in   = $urandom_range(0, 1) ? 6'd15 : 6'd63;
      m_in   = $urandom_range(0, 1) ? 3'd1 : 3'd7;
    end
    @(posedge clk); #2;
    clear = 1'b0; start = 1'b0;
    repeat (20) @(posedge clk);

    // Asynchronous reset in the middle of a fetch.
    pulse_clear();
    @(posedge clk); #2;
    start = 1'b1; lambda = 6'd7; n_in = 6'd63; m_in = 3'd7;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("t6_rst_busy", g, busy[g], 0);
      check("t6_rst_a_we", g, a_we[g], 0);
      check("t6_rst_phi_addr", g, phi_addr[g], 0);
      check("t6_rst_status", g, status[g], 0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(6'd2, 6'd15, 3'd1, l0, l1);
    check("t6_recover_latency", 0, l0, 5);
    check("t6_recover_latency", 1, l1, 6);
    for (int g = 0; g < 2; g++) check("t6_recover_cnt", g, atom_cnt[g], 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
